// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl
// Sequencer for an iterative AES inverse cipher. One 128-bit state register is
// loaded with ciphertext and then rewritten once per round key, from Nr down to
// 0. Each step waits for the key store to present the requested key. The
// finished plaintext is held until the consumer takes it.
module aes_inv_round_ctrl #(
  parameter int KEY_BITS = 128,
  parameter int RK_W     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic [RK_W-1:0] rk_idx,
  input  logic            rk_valid,
  output logic            load_in,
  output logic            state_we,
  output logic [1:0]      op_sel,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int NR = (KEY_BITS == 256) ? 14 : 10;
  localparam logic [RK_W-1:0] RK_NR  = RK_W'(NR);
  localparam logic [RK_W-1:0] RK_ONE = RK_W'(1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] ROUND = 3'd2;
  localparam logic [2:0] FINAL = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [1:0] OP_ARK   = 2'b00;
  localparam logic [1:0] OP_ROUND = 2'b01;
  localparam logic [1:0] OP_FINAL = 2'b10;

  logic [2:0]      state;
  logic [2:0]      next_state;
  logic [RK_W-1:0] next_rk;
  logic            key_step;

  // A datapath write happens only in a key-consuming state with the key present.
  assign key_step = rk_valid && !flush &&
                    ((state == INIT) || (state == ROUND) || (state == FINAL));

  assign state_we  = key_step;
  assign load_in   = (state == IDLE) && in_valid && !flush;
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // Datapath operation is a pure function of the FSM state.
  always_comb begin
    op_sel = OP_ARK;
    case (state)
      ROUND:   op_sel = OP_ROUND;
      FINAL:   op_sel = OP_FINAL;
      default: op_sel = OP_ARK;
    endcase
  end

  // Next state and next key index; flush overrides every other transition.
  always_comb begin
    next_state = state;
    next_rk    = rk_idx;
    if (flush) begin
      next_state = IDLE;
      next_rk    = RK_NR;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            next_state = INIT;
            next_rk    = RK_NR;
          end
        end
        INIT: begin
          if (rk_valid) begin
            next_state = ROUND;
            next_rk    = RK_NR - RK_ONE;
          end
        end
        ROUND: begin
          if (rk_valid) begin
            next_rk = rk_idx - RK_ONE;
            if (rk_idx == RK_ONE) begin
              next_state = FINAL;
            end
          end
        end
        FINAL: begin
          if (rk_valid) begin
            next_state = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            next_state = IDLE;
            next_rk    = RK_NR;
          end
        end
        default: begin
          next_state = IDLE;
          next_rk    = RK_NR;
        end
      endcase
    end
  end

  // State and key-index registers; reset parks the controller in IDLE at key Nr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rk_idx <= RK_NR;
    end else begin
      state  <= next_state;
      rk_idx <= next_rk;
    end
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// tb_aes_inv_round_ctrl
// Directed bench for the AES inverse-round sequencer. It uses one AES-128 and
// one AES-256 instance. The two instances share every input except in_valid.
// The bench checks key order, op selects, write pulses, latency, stalls,
// backpressure, flush, asynchronous reset and back-to-back throughput.
module tb_aes_inv_round_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic iv, rkv, fl, ordy;
  logic use256;
  logic in_valid_a, in_valid_b;

  logic       in_ready_a, load_a, we_a, busy_a, ov_a;
  logic [3:0] rk_a;
  logic [1:0] op_a;
  logic       in_ready_b, load_b, we_b, busy_b, ov_b;
  logic [3:0] rk_b;
  logic [1:0] op_b;

  logic       in_ready_o, load_o, we_o, busy_o, ov_o;
  logic [3:0] rk_o;
  logic [1:0] op_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc;

  assign in_valid_a = iv && !use256;
  assign in_valid_b = iv && use256;

  aes_inv_round_ctrl #(.KEY_BITS(128), .RK_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .flush(fl), .rk_idx(rk_a), .rk_valid(rkv), .load_in(load_a),
    .state_we(we_a), .op_sel(op_a), .busy(busy_a), .out_valid(ov_a),
    .out_ready(ordy)
  );

  aes_inv_round_ctrl #(.KEY_BITS(256), .RK_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .flush(fl), .rk_idx(rk_b), .rk_valid(rkv), .load_in(load_b),
    .state_we(we_b), .op_sel(op_b), .busy(busy_b), .out_valid(ov_b),
    .out_ready(ordy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Global cycle counter used for throughput measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Observe whichever instance is currently under test.
  always_comb begin
    in_ready_o = use256 ? in_ready_b : in_ready_a;
    load_o     = use256 ? load_b     : load_a;
    we_o       = use256 ? we_b       : we_a;
    busy_o     = use256 ? busy_b     : busy_a;
    ov_o       = use256 ? ov_b       : ov_a;
    rk_o       = use256 ? rk_b       : rk_a;
    op_o       = use256 ? op_b       : op_a;
  end

  task automatic applyStimulus(input logic v, input logic k, input logic f, input logic r);
    iv   = v;
    rkv  = k;
    fl   = f;
    ordy = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Accept a block in the current cycle and run it to completion. Key stalls
  // are injected in INIT and at one ROUND index. The done block is held for
  // `hold` cycles and then drained. The task returns in the IDLE cycle that
  // follows the drain.
  task automatic runBlock(input int nr, input int init_stall, input int stall_idx,
                          input int round_stall, input int exp_lat, input int hold);
    int c;
    int idx;
    int pulses;
    int ist;
    int rst;
    applyStimulus(1, 1, 0, 1);
    #1;
    checkOutput("accept_in_ready", in_ready_o, 1);
    checkOutput("accept_load_in", load_o, 1);
    checkOutput("accept_rk_idx", rk_o, nr);
    accept_cyc = cyc;
    @(posedge clk); #1;
    applyStimulus(0, 1, 0, 1);
    c = 1;
    idx = nr;
    pulses = 0;
    ist = init_stall;
    rst = round_stall;
    while (!ov_o && c < 200) begin
      if (idx == nr && ist > 0) begin
        rkv = 1'b0;
        ist--;
      end else if (idx == stall_idx && idx != nr && rst > 0) begin
        rkv = 1'b0;
        rst--;
      end else begin
        rkv = 1'b1;
      end
      #1;
      checkOutput("run_rk_idx", rk_o, idx);
      checkOutput("run_op_sel", op_o, (idx == nr) ? 0 : ((idx == 0) ? 2 : 1));
      checkOutput("run_state_we", we_o, rkv);
      checkOutput("run_busy", busy_o, 1);
      checkOutput("run_in_ready", in_ready_o, 0);
      if (rkv) begin
        pulses++;
        idx--;
      end
      @(posedge clk); #1;
      c++;
    end
    checkOutput("latency", c, exp_lat);
    checkOutput("we_pulses", pulses, nr + 1);
    for (int h = 0; h < hold; h++) begin
      applyStimulus(1, 1, 0, 0);
      #1;
      checkOutput("hold_out_valid", ov_o, 1);
      checkOutput("hold_in_ready", in_ready_o, 0);
      checkOutput("hold_load_in", load_o, 0);
      checkOutput("hold_state_we", we_o, 0);
      checkOutput("hold_rk_idx", rk_o, 0);
      @(posedge clk); #1;
    end
    applyStimulus(1, 1, 0, 1);
    #1;
    checkOutput("drain_out_valid", ov_o, 1);
    checkOutput("drain_state_we", we_o, 0);
    @(posedge clk); #1;
    checkOutput("idle_in_ready", in_ready_o, 1);
    checkOutput("idle_out_valid", ov_o, 0);
    checkOutput("idle_busy", busy_o, 0);
    checkOutput("idle_rk_idx", rk_o, nr);
  endtask

  // Accept a block and advance with keys always present until rk_idx hits target.
  task automatic startAndRunTo(input int target);
    int n;
    applyStimulus(1, 1, 0, 1);
    @(posedge clk); #1;
    applyStimulus(0, 1, 0, 1);
    n = 0;
    while (rk_o != 4'(target) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reach_rk_idx", rk_o, target);
  endtask

  // Directed test sequence.
  initial begin
    int a0;
    int a1;
    int a2;
    use256 = 1'b0;
    applyStimulus(0, 1, 0, 1);
    rst_n = 1'b0;
    #12;
    checkOutput("reset_in_ready", in_ready_a, 1);
    checkOutput("reset_rk_idx", rk_a, 10);
    checkOutput("reset_rk_idx_256", rk_b, 14);
    checkOutput("reset_op_sel", op_a, 0);
    checkOutput("reset_load_in", load_a, 0);
    checkOutput("reset_state_we", we_a, 0);
    checkOutput("reset_busy", busy_a, 0);
    checkOutput("reset_out_valid", ov_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] T1 AES-128 no stalls");
    runBlock(10, 0, -1, 0, 12, 0);

    $display("[TB] T2 AES-256 no stalls");
    use256 = 1'b1;
    runBlock(14, 0, -1, 0, 16, 0);
    use256 = 1'b0;

    $display("[TB] T3 key stalls");
    runBlock(10, 3, 5, 2, 17, 0);

    $display("[TB] T4 output backpressure");
    runBlock(10, 0, -1, 0, 12, 4);
    runBlock(10, 0, -1, 0, 12, 0);

    $display("[TB] T5 flush and async reset");
    applyStimulus(1, 1, 1, 1);
    #1;
    checkOutput("flush_idle_load_in", load_a, 0);
    @(posedge clk); #1;
    checkOutput("flush_idle_in_ready", in_ready_a, 1);
    checkOutput("flush_idle_busy", busy_a, 0);
    startAndRunTo(6);
    applyStimulus(0, 1, 1, 1);
    #1;
    checkOutput("flush_state_we", we_a, 0);
    @(posedge clk); #1;
    applyStimulus(0, 1, 0, 1);
    checkOutput("flush_in_ready", in_ready_a, 1);
    checkOutput("flush_rk_idx", rk_a, 10);
    checkOutput("flush_busy", busy_a, 0);
    checkOutput("flush_out_valid", ov_a, 0);
    startAndRunTo(3);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_in_ready", in_ready_a, 1);
    checkOutput("areset_rk_idx", rk_a, 10);
    checkOutput("areset_busy", busy_a, 0);
    checkOutput("areset_state_we", we_a, 0);
    checkOutput("areset_out_valid", ov_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    runBlock(10, 0, -1, 0, 12, 0);

    $display("[TB] T6 back-to-back");
    runBlock(10, 0, -1, 0, 12, 0);
    a0 = accept_cyc;
    runBlock(10, 0, -1, 0, 12, 0);
    a1 = accept_cyc;
    runBlock(10, 0, -1, 0, 12, 0);
    a2 = accept_cyc;
    checkOutput("b2b_period_1", a1 - a0, 13);
    checkOutput("b2b_period_2", a2 - a1, 13);

    applyStimulus(0, 1, 0, 1);
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
